// File: rtl/register_writeback_pkg.sv
// Shared types for the register-file write-back path: register index, data word,
// buffered result entry and the arbitration source tag.
package register_writeback_pkg;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0]  reg_index_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam reg_index_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_index_t dest;
        word_t      value;
    } wb_entry_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/register_writeback_if.sv
// Bundle of the write-back block's result, issue, register-file and forward signals.
// slave is the write-back block's view; master is the surrounding pipeline's view.
interface register_writeback_if;
    import register_writeback_pkg::*;

    logic                alu_valid;
    logic                alu_ready;
    reg_index_t          alu_dest;
    word_t               alu_value;
    logic                mem_valid;
    logic                mem_ready;
    reg_index_t          mem_dest;
    word_t               mem_value;
    logic                issue_valid;
    logic                issue_ready;
    reg_index_t          issue_dest;
    logic [NUM_REGS-1:0] busy_mask;
    logic                write_enable;
    reg_index_t          selector_in1;
    word_t               value_in1;
    reg_index_t          forward_sel;
    logic                forward_hit;
    word_t               forward_value;

    modport slave (
        input  alu_valid, alu_dest, alu_value,
        input  mem_valid, mem_dest, mem_value,
        input  issue_valid, issue_dest, forward_sel,
        output alu_ready, mem_ready, issue_ready, busy_mask,
        output write_enable, selector_in1, value_in1,
        output forward_hit, forward_value
    );

    modport master (
        output alu_valid, alu_dest, alu_value,
        output mem_valid, mem_dest, mem_value,
        output issue_valid, issue_dest, forward_sel,
        input  alu_ready, mem_ready, issue_ready, busy_mask,
        input  write_enable, selector_in1, value_in1,
        input  forward_hit, forward_value
    );

endinterface

// File: rtl/register_writeback_result_fifo.sv
// Small synchronous FIFO of write-back entries; ready is registered from the
// next occupancy, so a full FIFO popping this cycle still shows ready=0.
module result_fifo
    import register_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push_valid,
    output logic      push_ready,
    input  wb_entry_t push_data,
    input  logic      pop,
    output wb_entry_t head,
    output logic      empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t         storage [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              ready_q;
    logic              push;
    logic              pop_ok;

    always_comb begin
        push       = push_valid && ready_q;
        pop_ok     = pop && (count != '0);
        count_next = count;
        if (push && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers wrap naturally at FIFO_DEPTH because the depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            storage[wr_ptr] <= push_data;
        end
    end

    assign head       = storage[rd_ptr];
    assign empty      = (count == '0);
    assign push_ready = ready_q;

endmodule

// File: rtl/register_writeback.sv
// Register-file write-port master: round-robin arbitration of ALU and load results,
// registered write port, busy scoreboard and same-cycle forward compare.
module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic           clock,
    input logic           reset,
    register_writeback_if.slave bus
);

    wb_entry_t           alu_in;
    wb_entry_t           mem_in;
    wb_entry_t           alu_head;
    wb_entry_t           mem_head;
    wb_entry_t           grant_entry;
    logic                alu_empty;
    logic                mem_empty;
    logic                alu_ready;
    logic                mem_ready;
    logic                grant_alu;
    logic                grant_mem;
    wb_src_e             rr_last;
    logic                write_enable_q;
    reg_index_t          selector_q;
    word_t               value_q;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_next;
    logic                issue_fire;

    assign alu_in = '{dest: bus.alu_dest, value: bus.alu_value};
    assign mem_in = '{dest: bus.mem_dest, value: bus.mem_value};

    result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (bus.alu_valid),
        .push_ready (alu_ready),
        .push_data  (alu_in),
        .pop        (grant_alu),
        .head       (alu_head),
        .empty      (alu_empty)
    );

    result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (bus.mem_valid),
        .push_ready (mem_ready),
        .push_data  (mem_in),
        .pop        (grant_mem),
        .head       (mem_head),
        .empty      (mem_empty)
    );

    // Round-robin only matters when both sources have a result waiting.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!alu_empty && !mem_empty) begin
            if (rr_last == WB_SRC_ALU) begin
                grant_mem = 1'b1;
            end else begin
                grant_alu = 1'b1;
            end
        end else if (!alu_empty) begin
            grant_alu = 1'b1;
        end else if (!mem_empty) begin
            grant_mem = 1'b1;
        end
        grant_entry = grant_mem ? mem_head : alu_head;
    end

    // A new claim wins over a commit to the same register in the same cycle.
    always_comb begin
        issue_fire = bus.issue_valid && !busy_q[bus.issue_dest] && (bus.issue_dest != REG_ZERO);
        busy_next  = busy_q;
        if (write_enable_q) begin
            busy_next[selector_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[bus.issue_dest] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last        <= WB_SRC_ALU;
            write_enable_q <= 1'b0;
            selector_q     <= REG_ZERO;
            value_q        <= '0;
            busy_q         <= '0;
        end else begin
            busy_q <= busy_next;
            if (grant_alu || grant_mem) begin
                rr_last        <= grant_mem ? WB_SRC_MEM : WB_SRC_ALU;
                write_enable_q <= (grant_entry.dest != REG_ZERO);
                selector_q     <= grant_entry.dest;
                value_q        <= grant_entry.value;
            end else begin
                write_enable_q <= 1'b0;
            end
        end
    end

    assign bus.alu_ready     = alu_ready;
    assign bus.mem_ready     = mem_ready;
    assign bus.issue_ready   = !busy_q[bus.issue_dest];
    assign bus.busy_mask     = busy_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.selector_in1  = selector_q;
    assign bus.value_in1     = value_q;
    assign bus.forward_hit   = write_enable_q && (selector_q == bus.forward_sel)
                               && (bus.forward_sel != REG_ZERO);
    assign bus.forward_value = value_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed plus randomized bench for register_writeback, checked every cycle against
// a queue-based reference model of the two result buffers, arbiter and scoreboard.
module tb_register_writeback;
    import register_writeback_pkg::*;

    localparam int DEPTH = 2;

    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    register_writeback_if bus ();

    register_writeback #(.FIFO_DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model state
    wb_entry_t   m_alu[$];
    wb_entry_t   m_mem[$];
    logic [31:0] m_busy  = '0;
    bit          m_rr_mem = 1'b0;
    bit          m_we     = 1'b0;
    reg_index_t  m_sel    = '0;
    word_t       m_val    = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance the model.
    task automatic step(input logic rst,
                        input logic av, input reg_index_t ad, input word_t aval,
                        input logic mv, input reg_index_t md, input word_t mval,
                        input logic iv, input reg_index_t id, input reg_index_t fs);
        bit          a_rdy;
        bit          b_rdy;
        bit          ga;
        bit          gm;
        wb_entry_t   ge;
        logic [31:0] nb;
        @(negedge clock);
        reset           = rst;
        bus.alu_valid   = av;
        bus.alu_dest    = ad;
        bus.alu_value   = aval;
        bus.mem_valid   = mv;
        bus.mem_dest    = md;
        bus.mem_value   = mval;
        bus.issue_valid = iv;
        bus.issue_dest  = id;
        bus.forward_sel = fs;
        #1;
        a_rdy = m_alu.size() < DEPTH;
        b_rdy = m_mem.size() < DEPTH;
        chk("alu_ready",     32'(bus.alu_ready),     32'(a_rdy));
        chk("mem_ready",     32'(bus.mem_ready),     32'(b_rdy));
        chk("issue_ready",   32'(bus.issue_ready),   32'(!m_busy[id]));
        chk("busy_mask",     bus.busy_mask,          m_busy);
        chk("write_enable",  32'(bus.write_enable),  32'(m_we));
        chk("selector_in1",  32'(bus.selector_in1),  32'(m_sel));
        chk("value_in1",     bus.value_in1,          m_val);
        chk("forward_hit",   32'(bus.forward_hit),   32'(m_we && m_sel == fs && fs != 5'd0));
        chk("forward_value", bus.forward_value,      m_val);
        if (rst) begin
            m_alu.delete();
            m_mem.delete();
            m_busy   = '0;
            m_rr_mem = 1'b0;
            m_we     = 1'b0;
            m_sel    = '0;
            m_val    = '0;
        end else begin
            ga = 1'b0;
            gm = 1'b0;
            if (m_alu.size() > 0 && m_mem.size() > 0) begin
                if (m_rr_mem) ga = 1'b1; else gm = 1'b1;
            end else if (m_alu.size() > 0) begin
                ga = 1'b1;
            end else if (m_mem.size() > 0) begin
                gm = 1'b1;
            end
            nb = m_busy;
            if (m_we) nb[m_sel] = 1'b0;
            if (iv && !m_busy[id] && id != 5'd0) nb[id] = 1'b1;
            nb[0]  = 1'b0;
            m_busy = nb;
            ge = '0;
            if (ga) begin ge = m_alu.pop_front(); m_rr_mem = 1'b0; end
            if (gm) begin ge = m_mem.pop_front(); m_rr_mem = 1'b1; end
            if (ga || gm) begin
                m_we  = (ge.dest != 5'd0);
                m_sel = ge.dest;
                m_val = ge.value;
            end else begin
                m_we = 1'b0;
            end
            if (av && a_rdy) m_alu.push_back('{dest: ad, value: aval});
            if (mv && b_rdy) m_mem.push_back('{dest: md, value: mval});
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.alu_valid   = 1'b0;
        bus.alu_dest    = '0;
        bus.alu_value   = '0;
        bus.mem_valid   = 1'b0;
        bus.mem_dest    = '0;
        bus.mem_value   = '0;
        bus.issue_valid = 1'b0;
        bus.issue_dest  = '0;
        bus.forward_sel = '0;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("rst_issue_rdy", 32'(bus.issue_ready), 32'd1);
        chk("rst_we", 32'(bus.write_enable), 32'd0);
        chk("rst_busy", bus.busy_mask, 32'd0);

        // Single write: issue r5, ALU result two cycles before the write appears
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0);
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        chk("single_busy_set", 32'(bus.busy_mask[5]), 32'd1);
        idle(1);
        idle(1);
        chk("single_we", 32'(bus.write_enable), 32'd1);
        chk("single_sel", 32'(bus.selector_in1), 32'd5);
        chk("single_val", bus.value_in1, 32'hDEADBEEF);
        idle(1);
        chk("single_busy_clr", 32'(bus.busy_mask[5]), 32'd0);

        // Contention: ALU r1,r2 and MEM r3,r4 with rr_last=ALU
        step(0, 1, 5'd1, 32'h101, 1, 5'd3, 32'h303, 0, 0, 0);
        step(0, 1, 5'd2, 32'h202, 1, 5'd4, 32'h404, 0, 0, 0);
        idle(1);
        chk("rr_w0", 32'(bus.selector_in1), 32'd3);
        idle(1);
        chk("rr_w1", 32'(bus.selector_in1), 32'd1);
        idle(1);
        chk("rr_w2", 32'(bus.selector_in1), 32'd4);
        idle(1);
        chk("rr_w3", 32'(bus.selector_in1), 32'd2);
        chk("rr_w3_val", bus.value_in1, 32'h202);

        // Backpressure: fill the ALU FIFO, third offer must be refused
        step(0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 0, 0);
        step(0, 1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0, 0, 0, 0);
        step(0, 1, 5'd14, 32'hE0, 0, 0, 0, 0, 0, 0);
        chk("bp_alu_ready", 32'(bus.alu_ready), 32'd0);
        idle(1);
        chk("bp_w10", 32'(bus.selector_in1), 32'd10);
        idle(1);
        chk("bp_w13", 32'(bus.selector_in1), 32'd13);
        idle(1);
        chk("bp_w12", bus.value_in1, 32'hC0);
        idle(1);
        chk("bp_no_r14", 32'(bus.write_enable), 32'd0);

        // Zero register: consumed but never written or forwarded
        step(0, 0, 0, 0, 1, 5'd0, 32'd1234, 0, 0, 0);
        idle(1);
        idle(1);
        chk("zero_we", 32'(bus.write_enable), 32'd0);
        chk("zero_busy0", 32'(bus.busy_mask[0]), 32'd0);
        chk("zero_fwd", 32'(bus.forward_hit), 32'd0);
        idle(1);

        // Hazards: WAW stall, set-wins-over-clear, forward during commit
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
        chk("waw_stall", 32'(bus.issue_ready), 32'd0);
        step(0, 1, 5'd9, 32'h99990000, 0, 0, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9);
        chk("commit_we", 32'(bus.write_enable), 32'd1);
        chk("commit_sel", 32'(bus.selector_in1), 32'd9);
        chk("issue9_ready", 32'(bus.issue_ready), 32'd1);
        chk("fwd_hit9", 32'(bus.forward_hit), 32'd1);
        chk("fwd_val9", bus.forward_value, 32'h99990000);
        idle(1);
        chk("busy9_kept", 32'(bus.busy_mask[9]), 32'd1);

        // Reset in the middle of traffic
        step(0, 1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 1, 5'd22, 0);
        step(0, 1, 5'd23, 32'h23, 1, 5'd24, 32'h24, 1, 5'd25, 0);
        step(1, 1, 5'd26, 32'h26, 1, 5'd27, 32'h27, 1, 5'd28, 0);
        step(1, 1, 5'd29, 32'h29, 1, 5'd30, 32'h30, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_we", 32'(bus.write_enable), 32'd0);
        chk("mid_rst_busy", bus.busy_mask, 32'd0);
        chk("mid_rst_alu_rdy", 32'(bus.alu_ready), 32'd1);
        chk("mid_rst_mem_rdy", 32'(bus.mem_ready), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       r;
            reg_index_t fs;
            r  = ($urandom_range(0, 79) == 0);
            fs = ($urandom_range(0, 1) == 1) ? m_sel : 5'($urandom_range(0, 31));
            step(r,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), word_t'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), word_t'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), fs);
        end
        idle(6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
